// File: rtl/vga_pkg.sv
// Shared timing types and mode constants for the VGA timing generator.
// Every timing field is TW bits; line totals are computed two bits wider.
package vga_pkg;

    localparam int TW = 12;

    typedef struct packed {
        logic [TW-1:0] h_visible;
        logic [TW-1:0] h_front;
        logic [TW-1:0] h_sync;
        logic [TW-1:0] h_back;
        logic [TW-1:0] v_visible;
        logic [TW-1:0] v_front;
        logic [TW-1:0] v_sync;
        logic [TW-1:0] v_back;
        logic          h_pol;
        logic          v_pol;
    } vga_timing_t;

    localparam vga_timing_t VGA_640x480 = '{
        h_visible: 12'd640, h_front: 12'd16, h_sync: 12'd96, h_back: 12'd48,
        v_visible: 12'd480, v_front: 12'd10, v_sync: 12'd2,  v_back: 12'd33,
        h_pol: 1'b0, v_pol: 1'b0
    };

    localparam vga_timing_t VGA_800x600 = '{
        h_visible: 12'd800, h_front: 12'd40, h_sync: 12'd128, h_back: 12'd88,
        v_visible: 12'd600, v_front: 12'd1,  v_sync: 12'd4,   v_back: 12'd23,
        h_pol: 1'b1, v_pol: 1'b1
    };

    // Full line/frame length; the two extra bits expose overflow of TW.
    function automatic logic [TW+1:0] timing_total(
        input logic [TW-1:0] vis,
        input logic [TW-1:0] fr,
        input logic [TW-1:0] sy,
        input logic [TW-1:0] bk
    );
        return {2'b00, vis} + {2'b00, fr} + {2'b00, sy} + {2'b00, bk};
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register used to align sync/valid with pixel data.
// DEPTH of 0 turns the block into a plain wire.
module vga_delay_line #(
    parameter int                 WIDTH   = 5,
    parameter int                 DEPTH   = 2,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, reset, en};
            assign dout = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_q [DEPTH];

            // Shift one stage per enabled pixel; hold otherwise.
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
                end else if (en) begin
                    stage_q[0] <= din;
                    for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
                end
            end

            assign dout = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Runtime-reconfigurable VGA timing generator with shadowed mode switch
// at frame boundaries and an enable-aligned output delay.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int          COORD_W    = TW,
    parameter int          IDX_W      = 20,
    parameter int          FCNT_W     = 8,
    parameter int          SYNC_DELAY = 2,
    parameter vga_timing_t DEF_TIMING = VGA_640x480
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_ce,
    input  vga_timing_t        cfg,
    input  logic               cfg_load,
    output logic               cfg_pending,
    output logic               cfg_err,
    output logic [COORD_W-1:0] horizontal_coord,
    output logic [COORD_W-1:0] vertical_coord,
    output logic [IDX_W-1:0]   idx,
    output logic               h_sync,
    output logic               v_sync,
    output logic               valid,
    output logic               line_start,
    output logic               frame_start,
    output logic [FCNT_W-1:0]  frame_count
);

    localparam int LW = COORD_W + 2;
    localparam logic [LW-1:0] MAX_LINE = {2'b00, {COORD_W{1'b1}}};
    localparam logic [4:0] DLY_RST = {~DEF_TIMING.h_pol, ~DEF_TIMING.v_pol, 3'b000};

    vga_timing_t        active_q, active_d;
    vga_timing_t        pend_q, pend_d;
    logic               pend_vld_q, pend_vld_d;
    logic               err_q, err_d;
    logic [COORD_W-1:0] h_q, h_d;
    logic [COORD_W-1:0] v_q, v_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [FCNT_W-1:0]  fcnt_q, fcnt_d;

    logic [LW-1:0] h_total, v_total;
    logic [LW-1:0] cfg_h_total, cfg_v_total;
    logic [LW-1:0] hs_start, hs_end, vs_start, vs_end;
    logic [LW-1:0] hx, vx;
    logic          h_last, v_last, frame_wrap;
    logic          cfg_ok, cfg_take;
    logic          hs_raw, vs_raw, vis_raw, ls_raw, fs_raw;
    logic          hs_pol, vs_pol;
    logic [4:0]    dly_in, dly_out;

    // Geometry of the running mode.
    always_comb begin
        h_total  = timing_total(active_q.h_visible, active_q.h_front,
                                active_q.h_sync, active_q.h_back);
        v_total  = timing_total(active_q.v_visible, active_q.v_front,
                                active_q.v_sync, active_q.v_back);
        hs_start = {2'b00, active_q.h_visible} + {2'b00, active_q.h_front};
        hs_end   = hs_start + {2'b00, active_q.h_sync};
        vs_start = {2'b00, active_q.v_visible} + {2'b00, active_q.v_front};
        vs_end   = vs_start + {2'b00, active_q.v_sync};
        hx       = {2'b00, h_q};
        vx       = {2'b00, v_q};
        h_last   = (hx == h_total - LW'(1));
        v_last   = (vx == v_total - LW'(1));
        frame_wrap = pix_ce && h_last && v_last;
    end

    // Validate an incoming mode before it may be shadowed.
    always_comb begin
        cfg_h_total = timing_total(cfg.h_visible, cfg.h_front,
                                   cfg.h_sync, cfg.h_back);
        cfg_v_total = timing_total(cfg.v_visible, cfg.v_front,
                                   cfg.v_sync, cfg.v_back);
        cfg_ok = (cfg.h_visible != '0) && (cfg.h_sync != '0) &&
                 (cfg.v_visible != '0) && (cfg.v_sync != '0) &&
                 (cfg_h_total <= MAX_LINE) && (cfg_v_total <= MAX_LINE);
        cfg_take = cfg_load && cfg_ok;
    end

    // Raw per-pixel flags from the undelayed counters.
    always_comb begin
        hs_raw  = (hx >= hs_start) && (hx < hs_end);
        vs_raw  = (vx >= vs_start) && (vx < vs_end);
        hs_pol  = active_q.h_pol ? hs_raw : ~hs_raw;
        vs_pol  = active_q.v_pol ? vs_raw : ~vs_raw;
        vis_raw = (h_q < active_q.h_visible) && (v_q < active_q.v_visible);
        ls_raw  = (h_q == '0);
        fs_raw  = ls_raw && (v_q == '0);
        dly_in  = {hs_pol, vs_pol, vis_raw, ls_raw, fs_raw};
    end

    // Raster counters, linear index and frame counter advance on pix_ce.
    always_comb begin
        h_d    = h_q;
        v_d    = v_q;
        idx_d  = idx_q;
        fcnt_d = fcnt_q;
        if (pix_ce) begin
            if (h_last) begin
                h_d = '0;
                v_d = v_last ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
            if (frame_wrap) begin
                idx_d  = '0;
                fcnt_d = fcnt_q + 1'b1;
            end else if (vis_raw) begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Shadow register: accepted modes wait for the frame wrap.
    always_comb begin
        active_d   = active_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        err_d      = cfg_load && !cfg_ok;
        if (frame_wrap) begin
            pend_vld_d = 1'b0;
            if (cfg_take) begin
                active_d = cfg;
            end else if (pend_vld_q) begin
                active_d = pend_q;
            end
        end else if (cfg_take) begin
            pend_d     = cfg;
            pend_vld_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_q   <= DEF_TIMING;
            pend_q     <= DEF_TIMING;
            pend_vld_q <= 1'b0;
            err_q      <= 1'b0;
            h_q        <= '0;
            v_q        <= '0;
            idx_q      <= '0;
            fcnt_q     <= '0;
        end else begin
            active_q   <= active_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            err_q      <= err_d;
            h_q        <= h_d;
            v_q        <= v_d;
            idx_q      <= idx_d;
            fcnt_q     <= fcnt_d;
        end
    end

    vga_delay_line #(
        .WIDTH   (5),
        .DEPTH   (SYNC_DELAY),
        .RST_VAL (DLY_RST)
    ) u_dly (
        .clk   (clk),
        .reset (reset),
        .en    (pix_ce),
        .din   (dly_in),
        .dout  (dly_out)
    );

    assign horizontal_coord = h_q;
    assign vertical_coord   = v_q;
    assign idx              = idx_q;
    assign frame_count      = fcnt_q;
    assign cfg_pending      = pend_vld_q;
    assign cfg_err          = err_q;
    assign h_sync           = dly_out[4];
    assign v_sync           = dly_out[3];
    assign valid            = dly_out[2];
    assign line_start       = dly_out[1] & pix_ce;
    assign frame_start      = dly_out[0] & pix_ce;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two instances (default 640x480 with no delay,
// small custom default with delay 2) checked against a position-based model.
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam vga_timing_t DEF_B = '{
        h_visible: 12'd8, h_front: 12'd2, h_sync: 12'd3, h_back: 12'd2,
        v_visible: 12'd5, v_front: 12'd1, v_sync: 12'd2, v_back: 12'd2,
        h_pol: 1'b1, v_pol: 1'b0
    };

    typedef struct packed {
        logic        pend;
        logic        err;
        logic [11:0] h;
        logic [11:0] v;
        logic [19:0] idx;
        logic        hs;
        logic        vs;
        logic        vld;
        logic        ls;
        logic        fs;
        logic [7:0]  fc;
    } obs_t;

    typedef struct {
        vga_timing_t cfg;
        bit          err;
        bit          pend;
    } cfgvec_t;

    logic        clk = 1'b0;
    logic        reset, pix_ce, cfg_load;
    vga_timing_t cfg;

    logic        a_pend, a_err, a_hs, a_vs, a_vld, a_ls, a_fs;
    logic [11:0] a_h, a_v;
    logic [19:0] a_idx;
    logic [7:0]  a_fc;
    logic        b_pend, b_err, b_hs, b_vs, b_vld, b_ls, b_fs;
    logic [11:0] b_h, b_v;
    logic [19:0] b_idx;
    logic [7:0]  b_fc;

    obs_t obs [2];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(.SYNC_DELAY(0)) dut_a (
        .clk(clk), .reset(reset), .pix_ce(pix_ce), .cfg(cfg),
        .cfg_load(cfg_load), .cfg_pending(a_pend), .cfg_err(a_err),
        .horizontal_coord(a_h), .vertical_coord(a_v), .idx(a_idx),
        .h_sync(a_hs), .v_sync(a_vs), .valid(a_vld),
        .line_start(a_ls), .frame_start(a_fs), .frame_count(a_fc)
    );

    vga_timing_gen #(.SYNC_DELAY(2), .DEF_TIMING(DEF_B)) dut_b (
        .clk(clk), .reset(reset), .pix_ce(pix_ce), .cfg(cfg),
        .cfg_load(cfg_load), .cfg_pending(b_pend), .cfg_err(b_err),
        .horizontal_coord(b_h), .vertical_coord(b_v), .idx(b_idx),
        .h_sync(b_hs), .v_sync(b_vs), .valid(b_vld),
        .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc)
    );

    always_comb begin
        obs[0] = '{a_pend, a_err, a_h, a_v, a_idx, a_hs, a_vs, a_vld, a_ls, a_fs, a_fc};
        obs[1] = '{b_pend, b_err, b_h, b_v, b_idx, b_hs, b_vs, b_vld, b_ls, b_fs, b_fc};
    end

    // ---------------- reference model ----------------
    vga_timing_t m_def  [2];
    int          m_dly  [2];
    vga_timing_t m_act  [2];
    vga_timing_t m_pend [2];
    bit          m_pv   [2];
    bit          m_err  [2];
    int          m_p    [2];
    int          m_fc   [2];
    int          m_ne   [2];
    logic [4:0]  m_ring [2][64];

    function automatic int hl(vga_timing_t t);
        return int'(t.h_visible) + int'(t.h_front) + int'(t.h_sync) + int'(t.h_back);
    endfunction

    function automatic int vl(vga_timing_t t);
        return int'(t.v_visible) + int'(t.v_front) + int'(t.v_sync) + int'(t.v_back);
    endfunction

    function automatic bit cfg_good(vga_timing_t t);
        return t.h_visible != 0 && t.h_sync != 0 && t.v_visible != 0 &&
               t.v_sync != 0 && hl(t) <= 4095 && vl(t) <= 4095;
    endfunction

    function automatic vga_timing_t mk(int hv, int hf, int hs, int hb,
                                       int vv, int vf, int vs, int vb,
                                       bit hp, bit vp);
        vga_timing_t t;
        t.h_visible = 12'(hv); t.h_front = 12'(hf);
        t.h_sync    = 12'(hs); t.h_back  = 12'(hb);
        t.v_visible = 12'(vv); t.v_front = 12'(vf);
        t.v_sync    = 12'(vs); t.v_back  = 12'(vb);
        t.h_pol = hp; t.v_pol = vp;
        return t;
    endfunction

    // Flags of the pixel the model currently sits on: {hs, vs, valid, ls, fs}.
    function automatic logic [4:0] raw_sample(int d);
        vga_timing_t t = m_act[d];
        int h = m_p[d] % hl(t);
        int v = m_p[d] / hl(t);
        int hs0 = int'(t.h_visible) + int'(t.h_front);
        int vs0 = int'(t.v_visible) + int'(t.v_front);
        bit hs = (h >= hs0) && (h < hs0 + int'(t.h_sync));
        bit vs = (v >= vs0) && (v < vs0 + int'(t.v_sync));
        bit vld = (h < int'(t.h_visible)) && (v < int'(t.v_visible));
        return {t.h_pol ? hs : !hs, t.v_pol ? vs : !vs, vld, h == 0, m_p[d] == 0};
    endfunction

    function automatic obs_t expect_obs(int d);
        obs_t e;
        vga_timing_t t = m_act[d];
        int h = m_p[d] % hl(t);
        int v = m_p[d] / hl(t);
        int ix;
        logic [4:0] s;
        if (v >= int'(t.v_visible)) ix = int'(t.v_visible) * int'(t.h_visible);
        else ix = v * int'(t.h_visible) + ((h < int'(t.h_visible)) ? h : int'(t.h_visible));
        if (m_dly[d] == 0) s = raw_sample(d);
        else if (m_ne[d] >= m_dly[d]) s = m_ring[d][(m_ne[d] - m_dly[d]) % 64];
        else s = {~m_def[d].h_pol, ~m_def[d].v_pol, 3'b000};
        e.pend = m_pv[d];
        e.err  = m_err[d];
        e.h    = 12'(h);
        e.v    = 12'(v);
        e.idx  = 20'(ix);
        e.hs   = s[4];
        e.vs   = s[3];
        e.vld  = s[2];
        e.ls   = s[1] & pix_ce;
        e.fs   = s[0] & pix_ce;
        e.fc   = 8'(m_fc[d]);
        return e;
    endfunction

    task automatic model_step(int d);
        bit ok;
        if (reset) begin
            m_act[d] = m_def[d];
            m_pv[d]  = 1'b0;
            m_err[d] = 1'b0;
            m_p[d]   = 0;
            m_fc[d]  = 0;
            m_ne[d]  = 0;
            return;
        end
        ok = cfg_good(cfg);
        m_err[d] = cfg_load && !ok;
        if (pix_ce) begin
            m_ring[d][m_ne[d] % 64] = raw_sample(d);
            m_ne[d]++;
            if (m_p[d] == hl(m_act[d]) * vl(m_act[d]) - 1) begin
                m_p[d] = 0;
                m_fc[d]++;
                if (cfg_load && ok) m_act[d] = cfg;
                else if (m_pv[d]) m_act[d] = m_pend[d];
                m_pv[d] = 1'b0;
                return;
            end
            m_p[d]++;
        end
        if (cfg_load && ok) begin
            m_pend[d] = cfg;
            m_pv[d]   = 1'b1;
        end
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // One clock: model follows the same inputs, then both DUTs are compared.
    task automatic tick();
        obs_t e;
        @(posedge clk);
        for (int d = 0; d < 2; d++) model_step(d);
        #1;
        for (int d = 0; d < 2; d++) begin
            e = expect_obs(d);
            n_chk++;
            if (obs[d] !== e) begin
                n_fail++;
                $display("FAIL model_d%0d @%0t: got %h expected %h", d, $time, obs[d], e);
            end
        end
        @(negedge clk);
    endtask

    function automatic vga_timing_t rand_cfg();
        vga_timing_t t;
        t = mk($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 2),
               $urandom_range(0, 2), $urandom_range(0, 2),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 9) == 0) t.h_visible = 12'd4090;
        return t;
    endfunction

    cfgvec_t tbl [8];

    initial begin
        int first_low, last_low, cnt, v1_at, bad, seen;
        int maxh, maxv, maxidx, nfs;
        logic [11:0] prev_h;
        logic [11:0] hh [0:127];

        tbl[0] = '{mk(0, 1, 2, 1, 3, 1, 1, 1, 0, 0), 1'b1, 1'b0};
        tbl[1] = '{mk(4, 1, 0, 1, 3, 1, 1, 1, 0, 0), 1'b1, 1'b0};
        tbl[2] = '{mk(4, 1, 2, 1, 0, 1, 1, 1, 0, 0), 1'b1, 1'b0};
        tbl[3] = '{mk(4, 1, 2, 1, 3, 1, 0, 1, 0, 0), 1'b1, 1'b0};
        tbl[4] = '{mk(4000, 50, 45, 1, 3, 1, 1, 1, 0, 0), 1'b1, 1'b0};
        tbl[5] = '{mk(4000, 50, 44, 1, 3, 1, 1, 1, 0, 0), 1'b0, 1'b1};
        tbl[6] = '{mk(4, 1, 2, 1, 4000, 90, 5, 1, 0, 0), 1'b1, 1'b1};
        tbl[7] = '{mk(4, 0, 2, 0, 3, 0, 1, 0, 0, 0), 1'b0, 1'b1};

        m_def[0] = VGA_640x480; m_dly[0] = 0;
        m_def[1] = DEF_B;       m_dly[1] = 2;

        reset = 1'b1; pix_ce = 1'b0; cfg_load = 1'b0; cfg = VGA_800x600;
        tick();
        tick();
        chk("rst_h", 32'(b_h), 0);
        chk("rst_v", 32'(b_v), 0);
        chk("rst_idx", 32'(b_idx), 0);
        chk("rst_fc", 32'(b_fc), 0);
        chk("rst_pend", 32'(b_pend), 0);
        chk("rst_err", 32'(b_err), 0);
        chk("rst_valid", 32'(b_vld), 0);
        chk("rst_fs", 32'(b_fs), 0);
        chk("rst_hs_b", 32'(b_hs), 0);
        chk("rst_vs_b", 32'(b_vs), 1);
        chk("rst_hs_a", 32'(a_hs), 1);
        reset = 1'b0;

        // cfg validation table, counters frozen
        foreach (tbl[i]) begin
            cfg = tbl[i].cfg;
            cfg_load = 1'b1;
            tick();
            cfg_load = 1'b0;
            chk($sformatf("cfg_err_%0d", i), 32'(b_err), 32'(tbl[i].err));
            chk($sformatf("cfg_pend_%0d", i), 32'(a_pend), 32'(tbl[i].pend));
            tick();
            chk($sformatf("cfg_err_clr_%0d", i), 32'(b_err), 0);
            chk($sformatf("cfg_hold_h_%0d", i), 32'(b_h), 0);
        end

        // default 640x480 line, and delayed valid on the small instance
        reset = 1'b1; tick(); reset = 1'b0; pix_ce = 1'b1;
        first_low = -1; last_low = -1; cnt = 0; v1_at = -1;
        for (int i = 1; i <= 820; i++) begin
            tick();
            if (i == 1) chk("dly_valid_1", 32'(b_vld), 0);
            if (i == 2) begin
                chk("dly_valid_2", 32'(b_vld), 1);
                chk("undelayed_h", 32'(b_h), 2);
            end
            if (a_v == 0 && a_hs == 1'b0) begin
                if (first_low < 0) first_low = int'(a_h);
                last_low = int'(a_h);
                cnt++;
            end
            if (a_v == 1 && v1_at < 0) v1_at = i;
        end
        chk("hsync_first", 32'(first_low), 656);
        chk("hsync_last", 32'(last_low), 751);
        chk("hsync_len", 32'(cnt), 96);
        chk("line_len", 32'(v1_at), 800);

        // pix_ce every other cycle
        reset = 1'b1; pix_ce = 1'b0; tick(); reset = 1'b0;
        cnt = 0; bad = 0;
        for (int i = 0; i < 3200; i++) begin
            pix_ce = (i % 2 == 0);
            prev_h = a_h;
            tick();
            if (a_ls) cnt++;
            if (!pix_ce && a_h != prev_h) bad++;
        end
        chk("ce_ls_count", 32'(cnt), 2);
        chk("ce_hold", 32'(bad), 0);
        chk("ce_v", 32'(a_v), 2);

        // mid-frame load, switch at the frame wrap
        reset = 1'b1; pix_ce = 1'b0; tick(); reset = 1'b0; pix_ce = 1'b1;
        repeat (20) tick();
        cfg = mk(4, 1, 2, 1, 3, 1, 1, 1, 1, 1);
        cfg_load = 1'b1; tick(); cfg_load = 1'b0;
        chk("mid_pend", 32'(b_pend), 1);
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            if (b_fc == 8'd1) seen = 1;
        end
        chk("mid_wrap_seen", 32'(seen), 1);
        chk("mid_pend_clr", 32'(b_pend), 0);
        maxh = 0; maxv = 0; maxidx = 0; nfs = 0; bad = 0;
        for (int t = 1; t <= 96; t++) begin
            tick();
            hh[t] = b_h;
            if (int'(b_h) > maxh) maxh = int'(b_h);
            if (int'(b_v) > maxv) maxv = int'(b_v);
            if (int'(b_idx) > maxidx) maxidx = int'(b_idx);
            if (b_fs) nfs++;
            if (t >= 3 && b_hs !== (hh[t-2] == 5 || hh[t-2] == 6)) bad++;
        end
        chk("small_maxh", 32'(maxh), 7);
        chk("small_maxv", 32'(maxv), 5);
        chk("small_maxidx", 32'(maxidx), 12);
        chk("small_fs", 32'(nfs), 2);
        chk("small_hs_pos", 32'(bad), 0);

        // load exactly on the wrap cycle
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (b_h == 12'd7 && b_v == 12'd5) seen = 1;
            else tick();
        end
        chk("wrapload_found", 32'(seen), 1);
        cfg = mk(6, 1, 1, 1, 4, 1, 1, 1, 0, 0);
        cfg_load = 1'b1; tick(); cfg_load = 1'b0;
        chk("wrapload_pend", 32'(b_pend), 0);
        chk("wrapload_h", 32'(b_h), 0);
        repeat (9) tick();
        chk("wrapload_len_h", 32'(b_h), 0);
        chk("wrapload_len_v", 32'(b_v), 1);

        // reset mid-frame with a pending mode
        cfg = VGA_800x600;
        cfg_load = 1'b1; tick(); cfg_load = 1'b0;
        repeat (5) tick();
        chk("rstmid_pend_pre", 32'(b_pend), 1);
        reset = 1'b1; tick();
        chk("rstmid_h", 32'(b_h), 0);
        chk("rstmid_v", 32'(b_v), 0);
        chk("rstmid_idx", 32'(b_idx), 0);
        chk("rstmid_fc", 32'(b_fc), 0);
        chk("rstmid_pend", 32'(b_pend), 0);
        reset = 1'b0;
        repeat (15) tick();
        chk("rstmid_def_h", 32'(b_h), 0);
        chk("rstmid_def_v", 32'(b_v), 1);

        // random traffic against the model
        for (int i = 0; i < 6000 && n_fail <= 40; i++) begin
            pix_ce   = ($urandom_range(0, 3) != 0);
            cfg_load = ($urandom_range(0, 39) == 0);
            cfg      = rand_cfg();
            reset    = ($urandom_range(0, 2999) == 0);
            tick();
        end
        cfg_load = 1'b0; reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
